// File: rtl/count_core.sv
// Mod-31 up/down counter with an IDLE/UP/DOWN direction FSM, a one-cycle wrap pulse
// and a saturating wrap tally. Every output comes straight from a register.
module count_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       load,
  input  logic [4:0] din,
  input  logic       clr_wraps,
  output logic [4:0] count,
  output logic       dir,
  output logic       wrap,
  output logic [7:0] wraps,
  output logic [1:0] state
);

  localparam logic [4:0] MaxCount = 5'd30;
  localparam logic [7:0] MaxWraps = 8'd255;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StUp   = 2'b01,
    StDown = 2'b10,
    StBad  = 2'b11
  } state_e;

  state_e     st_q;
  logic [4:0] load_val;
  logic       wrap_ev;

  assign state = st_q;

  // din above the legal range loads the top value
  assign load_val = (din > MaxCount) ? MaxCount : din;

  // A wrap only happens on a real step in the current run direction
  assign wrap_ev = en && !load &&
                   (((st_q == StUp) && !mode && (count == MaxCount)) ||
                    ((st_q == StDown) && mode && (count == 5'd0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= StIdle;
      count <= 5'd0;
      dir   <= 1'b0;
      wrap  <= 1'b0;
      wraps <= 8'd0;
    end else begin
      wrap <= wrap_ev;

      if (clr_wraps) begin
        wraps <= 8'd0;
      end else if (wrap_ev && (wraps != MaxWraps)) begin
        wraps <= wraps + 8'd1;
      end

      unique case (st_q)
        StIdle: begin
          if (load) begin
            count <= load_val;
          end else if (en) begin
            st_q <= mode ? StDown : StUp;
            dir  <= mode;
          end
        end
        StUp, StDown: begin
          if (load) begin
            count <= load_val;
            if (!en) st_q <= StIdle;
          end else if (!en) begin
            st_q <= StIdle;
          end else if (mode != (st_q == StDown)) begin
            // Turnaround: change direction, count holds for this cycle
            st_q <= mode ? StDown : StUp;
            dir  <= mode;
          end else if (st_q == StUp) begin
            count <= (count == MaxCount) ? 5'd0 : count + 5'd1;
          end else begin
            count <= (count == 5'd0) ? MaxCount : count - 5'd1;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_count_core.sv
// Bench for count_core: directed scenarios plus random stimulus, each cycle compared
// against a behavioural model of the counter rules.
module tb_count_core;

  logic       clk = 1'b0;
  logic       rst, en, mode, load, clr_wraps;
  logic [4:0] din;
  logic [4:0] count;
  logic       dir, wrap;
  logic [7:0] wraps;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Model: run_st 0 = idle, 1 = counting up, 2 = counting down
  int m_cnt, m_dir, m_wrap, m_wraps, m_st;

  count_core dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .din       (din),
    .clr_wraps (clr_wraps),
    .count     (count),
    .dir       (dir),
    .wrap      (wrap),
    .wraps     (wraps),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int w;
    if (rst) begin
      m_cnt = 0; m_dir = 0; m_wrap = 0; m_wraps = 0; m_st = 0;
    end else begin
      w = 0;
      if (load) begin
        m_cnt = (din > 30) ? 30 : int'(din);
        if (!en) m_st = 0;
      end else if (!en) begin
        m_st = 0;
      end else if (m_st == 0 || (m_st == 2) != mode) begin
        m_st = mode ? 2 : 1;
      end else begin
        w = mode ? (m_cnt == 0) : (m_cnt == 30);
        m_cnt = (m_cnt + (mode ? 30 : 1)) % 31;
      end
      if (m_st == 1) m_dir = 0;
      if (m_st == 2) m_dir = 1;
      m_wrap = w;
      if (clr_wraps) m_wraps = 0;
      else if (w && m_wraps < 255) m_wraps = m_wraps + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("count", 32'(count), 32'(m_cnt));
    check("dir", 32'(dir), 32'(m_dir));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("wraps", 32'(wraps), 32'(m_wraps));
    check("state", 32'(state), 32'(m_st));
  endtask

  task automatic drive(input logic r, input logic e, input logic m, input logic l,
                       input logic [4:0] d, input logic c);
    rst = r; en = e; mode = m; load = l; din = d; clr_wraps = c;
  endtask

  initial begin
    m_cnt = 0; m_dir = 0; m_wrap = 0; m_wraps = 0; m_st = 0;
    drive(1, 1, 1, 1, 5'd7, 1);
    step();
    check("reset_count", 32'(count), 32'd0);
    check("reset_state", 32'(state), 32'd0);

    // Count up through a full wrap
    drive(0, 1, 0, 0, 5'd0, 0);
    step();
    check("entry_hold", 32'(count), 32'd0);
    for (int i = 0; i < 32; i++) step();
    check("up_after_wrap", 32'(count), 32'd1);
    check("up_wraps", 32'(wraps), 32'd1);

    // Load 2 then count down across zero
    drive(0, 1, 1, 1, 5'd2, 0);
    step();
    drive(0, 1, 1, 0, 5'd0, 0);
    for (int i = 0; i < 5; i++) step();
    check("down_dir", 32'(dir), 32'd1);

    // Turnaround at 5
    drive(0, 1, 0, 1, 5'd5, 0);
    step();
    drive(0, 1, 0, 0, 5'd0, 0);
    step();
    step();
    drive(0, 1, 1, 0, 5'd0, 0);
    step();
    check("turn_hold", 32'(count), 32'd6);
    check("turn_state", 32'(state), 32'd2);
    step();
    step();

    // Clamped load while counting up
    drive(0, 1, 0, 0, 5'd0, 0);
    step();
    step();
    drive(0, 1, 0, 1, 5'd31, 0);
    step();
    check("clamp_load", 32'(count), 32'd30);
    drive(0, 1, 0, 0, 5'd0, 0);
    step();
    check("clamp_wrap", 32'(wrap), 32'd1);

    // Saturate the tally
    for (int i = 0; i < 31 * 258; i++) step();
    check("wraps_sat", 32'(wraps), 32'd255);

    // Clear coincident with a wrap
    drive(0, 1, 0, 1, 5'd30, 0);
    step();
    drive(0, 1, 0, 0, 5'd0, 1);
    step();
    check("clr_wraps_win", 32'(wraps), 32'd0);
    check("clr_wrap_pulse", 32'(wrap), 32'd1);
    drive(0, 1, 0, 0, 5'd0, 0);
    step();

    // Reset in the middle of a down count
    drive(0, 1, 1, 1, 5'd18, 0);
    step();
    drive(0, 1, 1, 0, 5'd0, 0);
    step();
    step();
    check("pre_rst_count", 32'(count), 32'd17);
    drive(1, 1, 1, 0, 5'd0, 0);
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    drive(0, 1, 1, 0, 5'd0, 0);
    step();
    check("rst_entry_hold", 32'(count), 32'd0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            (($urandom_range(0, 7) == 0) ? ~mode : mode), ($urandom_range(0, 19) == 0),
            5'($urandom_range(0, 31)), ($urandom_range(0, 29) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
